// File: rtl/hwpe_stream_fifo_ctrl_lvl.sv
// Pointer/level controller for a FIFO whose storage lives elsewhere: it produces
// write/read strobes and addresses, the occupancy, threshold flags and sticky error bits.
module hwpe_stream_fifo_ctrl_lvl #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned ALMOST_FULL_TH  = FIFO_DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_TH = 1,
  localparam int unsigned AW = (FIFO_DEPTH == 1) ? 1 : $clog2(FIFO_DEPTH),
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_valid_i,
  output logic          push_ready_o,
  output logic          pop_valid_o,
  input  logic          pop_ready_i,
  output logic          push_en_o,
  output logic          pop_en_o,
  output logic [AW-1:0] push_ptr_o,
  output logic [AW-1:0] pop_ptr_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AF_TH_L = LW'(ALMOST_FULL_TH);
  localparam logic [LW-1:0] AE_TH_L = LW'(ALMOST_EMPTY_TH);
  localparam logic [AW-1:0] LAST_L  = AW'(FIFO_DEPTH - 1);

  logic [AW-1:0] push_ptr_q, pop_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, underflow_q;

  // Handshakes: a transfer happens on a side in any cycle where its valid and
  // ready are both high. ready/valid are derived only from the registered level,
  // so neither side's handshake input feeds the other side's flag.
  assign full_o       = (level_q == DEPTH_L);
  assign empty_o      = (level_q == '0);
  assign push_ready_o = ~full_o;
  assign pop_valid_o  = ~empty_o;
  assign push_en_o    = push_valid_i & push_ready_o;
  assign pop_en_o     = pop_valid_o & pop_ready_i;

  assign push_ptr_o     = push_ptr_q;
  assign pop_ptr_o      = pop_ptr_q;
  assign level_o        = level_q;
  assign almost_full_o  = (level_q >= AF_TH_L);
  assign almost_empty_o = (level_q <= AE_TH_L);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Explicit wrap so non-power-of-2 depths index storage correctly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == LAST_L) return '0;
    else             return p + AW'(1);
  endfunction

  always_comb begin
    level_d = level_q;
    if (push_en_o && !pop_en_o)      level_d = level_q + LW'(1);
    else if (pop_en_o && !push_en_o) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear_i) begin
      push_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_en_o) push_ptr_q <= ptr_inc(push_ptr_q);
      if (pop_en_o)  pop_ptr_q  <= ptr_inc(pop_ptr_q);
      level_q <= level_d;
      // A push while full is only an error if no pop is freeing a slot this cycle.
      if (push_valid_i && full_o && !pop_ready_i) overflow_q  <= 1'b1;
      if (pop_ready_i && empty_o)                 underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hwpe_stream_fifo_ctrl_lvl.sv
// Bench for the FIFO controller at depth 5 (non-power-of-2) with custom thresholds:
// directed scenarios plus random traffic, write addresses scoreboarded against read addresses.
module tb_hwpe_stream_fifo_ctrl_lvl;

  localparam int D  = 5;
  localparam int AF = 3;
  localparam int AE = 2;
  localparam int AW = 3;
  localparam int LW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          push_valid_i;
  logic          push_ready_o;
  logic          pop_valid_o;
  logic          pop_ready_i;
  logic          push_en_o;
  logic          pop_en_o;
  logic [AW-1:0] push_ptr_o;
  logic [AW-1:0] pop_ptr_o;
  logic [LW-1:0] level_o;
  logic          empty_o, full_o, almost_full_o, almost_empty_o;
  logic          overflow_o, underflow_o;

  hwpe_stream_fifo_ctrl_lvl #(
    .FIFO_DEPTH      (D),
    .ALMOST_FULL_TH  (AF),
    .ALMOST_EMPTY_TH (AE)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .pop_valid_o    (pop_valid_o),
    .pop_ready_i    (pop_ready_i),
    .push_en_o      (push_en_o),
    .pop_en_o       (pop_en_o),
    .push_ptr_o     (push_ptr_o),
    .pop_ptr_o      (pop_ptr_o),
    .level_o        (level_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int m_lvl, m_wptr, m_rptr;
  bit m_ovf, m_udf;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_wptr = 0; m_rptr = 0; m_ovf = 0; m_udf = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_level",   32'(level_o), 0);
    check("rst_wptr",    32'(push_ptr_o), 0);
    check("rst_rptr",    32'(pop_ptr_o), 0);
    check("rst_empty",   32'(empty_o), 1);
    check("rst_full",    32'(full_o), 0);
    check("rst_pready",  32'(push_ready_o), 1);
    check("rst_pvalid",  32'(pop_valid_o), 0);
    check("rst_ovf",     32'(overflow_o), 0);
    check("rst_udf",     32'(underflow_o), 0);
    check("rst_aempty",  32'(almost_empty_o), 1);
    check("rst_afull",   32'(almost_full_o), 0);
  endtask

  // driver: one clock of stimulus, with all outputs checked mid-cycle
  task automatic cycle(input bit pv, input bit pr, input bit clr);
    bit f, e, hp, hq;
    @(negedge clk_i);
    push_valid_i = pv;
    pop_ready_i  = pr;
    clear_i      = clr;
    #1;
    f  = (m_lvl == D);
    e  = (m_lvl == 0);
    hp = pv && !f;
    hq = pr && !e;
    check("level",      32'(level_o), 32'(m_lvl));
    check("full",       32'(full_o), 32'(f));
    check("empty",      32'(empty_o), 32'(e));
    check("push_ready", 32'(push_ready_o), 32'(!f));
    check("pop_valid",  32'(pop_valid_o), 32'(!e));
    check("push_en",    32'(push_en_o), 32'(hp));
    check("pop_en",     32'(pop_en_o), 32'(hq));
    check("push_ptr",   32'(push_ptr_o), 32'(m_wptr));
    check("almost_full",  32'(almost_full_o), 32'(m_lvl >= AF));
    check("almost_empty", 32'(almost_empty_o), 32'(m_lvl <= AE));
    check("overflow",   32'(overflow_o), 32'(m_ovf));
    check("underflow",  32'(underflow_o), 32'(m_udf));
    // scoreboard: each read address must be the oldest outstanding write address
    if (hq) begin
      if (exp_q.size() == 0) check("sb_underrun", 1, 0);
      else                   check("pop_addr", 32'(pop_ptr_o), 32'(exp_q.pop_front()));
    end
    if (hp) exp_q.push_back(m_wptr[AW-1:0]);
    if (clr) begin
      model_reset();
    end else begin
      if (pv && f && !pr) m_ovf = 1;
      if (pr && e)        m_udf = 1;
      if (hp) m_wptr = (m_wptr + 1) % D;
      if (hq) m_rptr = (m_rptr + 1) % D;
      if (hp && !hq) m_lvl++;
      if (hq && !hp) m_lvl--;
    end
    @(posedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 1'b0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk_i) rst_ni = 1'b1;

    // fill to full, then one more push attempt flags overflow
    for (int i = 0; i < D; i++) cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("ovf_set", 32'(overflow_o), 1);
    cycle(0, 0, 1);

    // refill; push+pop while full pops only and raises no overflow
    for (int i = 0; i < D; i++) cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    check("full_pop_level", 32'(level_o), D - 1);
    check("full_pop_rptr",  32'(pop_ptr_o), 1);
    check("full_pop_ovf",   32'(overflow_o), 0);
    cycle(0, 0, 1);

    // streaming at level 1: pointers wrap several times
    cycle(1, 0, 0);
    for (int i = 0; i < 12; i++) cycle(1, 1, 0);
    cycle(0, 1, 0);

    // pop on empty: no strobe, underflow, then clear
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    check("udf_set", 32'(underflow_o), 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);

    // fill 0..D walking both thresholds, then drain
    for (int i = 0; i < D; i++) cycle(1, 0, 0);
    for (int i = 0; i < D; i++) cycle(0, 1, 0);

    // random traffic with rare clears
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0));

    // asynchronous reset mid-cycle at level 4
    cycle(0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk_i) rst_ni = 1'b1;
    cycle(1, 0, 0);
    cycle(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_fifo_ctrl_lvl.md
HWPE_STREAM_FIFO_CTRL_LVL -- requirements
Module: hwpe_stream_fifo_ctrl_lvl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: number of entries; any integer >= 1, not restricted to powers of 2.
REQ-002 Parameter ALMOST_FULL_TH, default FIFO_DEPTH-1: level at or above which almost_full_o asserts; legal range 0..FIFO_DEPTH.
REQ-003 Parameter ALMOST_EMPTY_TH, default 1: level at or below which almost_empty_o asserts; legal range 0..FIFO_DEPTH.
REQ-004 Derived widths: AW = (FIFO_DEPTH==1) ? 1 : $clog2(FIFO_DEPTH); LW = $clog2(FIFO_DEPTH+1).
REQ-005 Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear.
- push_valid_i  in  1  producer has data.
- push_ready_o  out  1  controller accepts push.
- pop_valid_o  out  1  entry available.
- pop_ready_i  in  1  consumer takes entry.
- push_en_o  out  1  storage write strobe.
- pop_en_o  out  1  storage read-advance strobe.
- push_ptr_o  out  AW  write address.
- pop_ptr_o  out  AW  read address.
- level_o  out  LW  current occupancy.
- empty_o / full_o  out  1 each  level==0 / level==FIFO_DEPTH.
- almost_full_o / almost_empty_o  out  1 each  threshold flags.
- overflow_o / underflow_o  out  1 each  sticky protocol-error flags.

Function
REQ-006 Registered state SHALL be: push pointer, pop pointer, level counter, two sticky error bits; all other outputs combinational from these and the inputs.
REQ-007 push_ready_o SHALL equal !full_o; pop_valid_o SHALL equal !empty_o; neither depends combinationally on the other side's handshake input.
REQ-008 A push handshake (push_valid_i & push_ready_o) SHALL assert push_en_o in the same cycle, with push_ptr_o giving the write address.
REQ-009 A pop handshake (pop_valid_o & pop_ready_i) SHALL assert pop_en_o in the same cycle, with pop_ptr_o giving the entry being consumed.
REQ-010 Each pointer SHALL advance by 1 on its handshake and wrap from FIFO_DEPTH-1 to 0 (valid for non-power-of-2 depths); for FIFO_DEPTH==1 both pointers SHALL stay 0.
REQ-011 Level update per cycle: push only +1; pop only -1; both or neither unchanged.
REQ-012 Push into an empty FIFO: pop_valid_o SHALL assert in the following cycle (latency 1, no fall-through).
REQ-013 When full: push_ready_o=0. A simultaneous pop SHALL be accepted, level becomes FIFO_DEPTH-1, and push_ready_o reasserts the next cycle.
REQ-014 When empty: pop_valid_o=0 and pop_ready_i SHALL be ignored.
REQ-015 Simultaneous push and pop at level 1..FIFO_DEPTH-1 SHALL both be accepted; both pointers advance and level is unchanged.
REQ-016 almost_full_o SHALL be (level_o >= ALMOST_FULL_TH); almost_empty_o SHALL be (level_o <= ALMOST_EMPTY_TH).
REQ-017 overflow_o SHALL set the cycle after push_valid_i=1 while full_o=1 and pop_ready_i=0.
REQ-018 underflow_o SHALL set the cycle after pop_ready_i=1 while empty_o=1.
REQ-019 overflow_o and underflow_o SHALL remain set until reset or clear_i, and SHALL NOT alter pointers or level.
REQ-020 clear_i=1 SHALL, at the next edge, zero both pointers, the level and both error bits, overriding any handshake that cycle; push_en_o/pop_en_o still reflect the combinational handshake during that cycle.

Reset
REQ-021 While rst_ni=0: pointers=0, level_o=0, empty_o=1, full_o=0, push_ready_o=1, pop_valid_o=0, overflow_o=0, underflow_o=0, almost_empty_o=1 (if ALMOST_EMPTY_TH>=0), almost_full_o=(ALMOST_FULL_TH==0).
REQ-022 Reset assertion mid-operation SHALL take effect immediately (asynchronously), discarding contents; deassertion SHALL be synchronised externally.

Verification
REQ-023 DEPTH=5: 5 pushes with no pop -> level 0..5, push_ptr 0,1,2,3,4 then 0; full_o=1; push_ready_o=0; 6th push_valid sets overflow_o.
REQ-024 DEPTH=5 full, with push_valid=1 and pop_ready=1 for one cycle -> pop only; level=4; pop_ptr 0->1; overflow_o stays 0.
REQ-025 DEPTH=3, 10 cycles of continuous push+pop at level 1 -> level constant 1; both pointers wrap 2->0; addresses match in order.
REQ-026 Empty, pop_ready_i=1 -> pop_en_o=0, underflow_o=1 next cycle; then clear_i=1 -> underflow_o=0, level 0.
REQ-027 DEPTH=8, AF_TH=6, AE_TH=2: fill 0->8 -> almost_empty_o high at levels 0-2; almost_full_o high at levels 6-8.
REQ-028 rst_ni pulsed low at level 4 -> all outputs at REQ-021 values within the same cycle.
